traffic_phase_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 66 ++++++
 rtl/traffic_phase_ctrl_if.sv | 26 ++
 rtl/traffic_phase_ctrl_phase_timer.sv | 31 +++
 rtl/traffic_phase_ctrl.sv | 167 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the four-approach traffic phase controller.
// Lamp codes, phase encoding, per-phase duration lookup and sequencing helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    LEFT   = 2'd3
  } traffic_light;

  typedef enum logic [3:0] {
    NS_GREEN   = 4'd0,
    NS_YELLOW  = 4'd1,
    EW_LEFT    = 4'd2,
    EW_YELLOW  = 4'd3,
    EW_GREEN   = 4'd4,
    EW_YELLOW2 = 4'd5,
    NS_LEFT    = 4'd6,
    NS_YELLOW2 = 4'd7,
    ALL_RED    = 4'd8,
    EMERG_HOLD = 4'd9,
    PED_WALK   = 4'd10
  } phase_t;

  // Duration in ticks of a phase; EMERG_HOLD is untimed and reports 1.
  function automatic int time_of(input phase_t p, input int green_t, input int yellow_t,
                                 input int left_t, input int allred_t, input int ped_t);
    case (p)
      NS_GREEN, EW_GREEN:                          time_of = green_t;
      NS_YELLOW, EW_YELLOW, EW_YELLOW2, NS_YELLOW2: time_of = yellow_t;
      EW_LEFT, NS_LEFT:                            time_of = left_t;
      ALL_RED:                                     time_of = allred_t;
      PED_WALK:                                    time_of = ped_t;
      default:                                     time_of = 32'sd1;
    endcase
  endfunction

  // A duration is legal when it is at least one tick and T-1 fits in w bits.
  function automatic bit time_fits(input int t, input int w);
    time_fits = (t >= 32'sd1) && (((t - 32'sd1) >> w) == 32'sd0);
  endfunction

  // Yellow that follows a green or left-turn phase.
  function automatic phase_t yellow_of(input phase_t p);
    case (p)
      NS_GREEN: yellow_of = NS_YELLOW;
      EW_LEFT:  yellow_of = EW_YELLOW;
      EW_GREEN: yellow_of = EW_YELLOW2;
      NS_LEFT:  yellow_of = NS_YELLOW2;
      default:  yellow_of = NS_YELLOW;
    endcase
  endfunction

  // Phase that resumes after the clearance interval following a yellow.
  function automatic phase_t after_red_of(input phase_t p);
    case (p)
      NS_YELLOW:  after_red_of = EW_LEFT;
      EW_YELLOW:  after_red_of = EW_GREEN;
      EW_YELLOW2: after_red_of = NS_LEFT;
      NS_YELLOW2: after_red_of = NS_GREEN;
      default:    after_red_of = NS_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control/lamp bundle of the traffic phase controller.
// master drives the requests and timebase, slave (the controller) drives the lamps.
interface traffic_phase_ctrl_if;
  import traffic_pkg::*;

  logic         tick;
  logic         emerg;
  logic         ped_req;
  traffic_light north;
  traffic_light south;
  traffic_light east;
  traffic_light west;
  logic         ped_walk;
  phase_t       phase;
  logic         cycle_done;

  modport master (
    output tick, emerg, ped_req,
    input  north, south, east, west, ped_walk, phase, cycle_done
  );

  modport slave (
    input  tick, emerg, ped_req,
    output north, south, east, west, ped_walk, phase, cycle_done
  );
endinterface

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Phase timer: counts ticks inside the current phase.
// 'last' carries the phase duration minus one, so expire = tick && cnt == dur-1.
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic [CNT_W-1:0] last,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Tick counter, restarted on every phase entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt <= {CNT_W{1'b0}};
    end else if (tick) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign expire = tick && (cnt == last);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-approach intersection phase controller with all-red clearance,
// emergency pre-emption and an optional pedestrian walk phase.
// Optional feature macro: PED_WALK_EN (pedestrian walk phase).
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GREEN_TIME  = 40,
  parameter int YELLOW_TIME = 5,
  parameter int LEFT_TIME   = 20,
  parameter int ALLRED_TIME = 2,
  parameter int PED_TIME    = 15
) (
  input logic                 clk,
  input logic                 rst,
  traffic_phase_ctrl_if.slave bus
);

  if (!time_fits(GREEN_TIME, CNT_W)) begin : g_bad_green
    $error("GREEN_TIME out of range for CNT_W");
  end
  if (!time_fits(YELLOW_TIME, CNT_W)) begin : g_bad_yellow
    $error("YELLOW_TIME out of range for CNT_W");
  end
  if (!time_fits(LEFT_TIME, CNT_W)) begin : g_bad_left
    $error("LEFT_TIME out of range for CNT_W");
  end
  if (!time_fits(ALLRED_TIME, CNT_W)) begin : g_bad_allred
    $error("ALLRED_TIME out of range for CNT_W");
  end
`ifdef PED_WALK_EN
  if (!time_fits(PED_TIME, CNT_W)) begin : g_bad_ped
    $error("PED_TIME out of range for CNT_W");
  end
`endif

  phase_t           state, next_state;
  phase_t           next_after_red, nar_next;
  logic             cycle_done, done_next;
  logic             ped_pending, pend_next, ped_set, enter_walk;
  logic             expire, timer_clear;
  logic [CNT_W-1:0] last;
  traffic_light     ns_lamp, ew_lamp;

`ifdef PED_WALK_EN
  assign ped_set = bus.ped_req;
`else
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
  assign ped_set = 1'b0;
`endif

  assign last        = CNT_W'(time_of(state, GREEN_TIME, YELLOW_TIME, LEFT_TIME,
                                      ALLRED_TIME, PED_TIME) - 32'sd1);
  // Timer restarts on every state change and stays at zero while held.
  assign timer_clear = (next_state != state) || (state == EMERG_HOLD);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick   (bus.tick),
    .clear  (timer_clear),
    .last   (last),
    .expire (expire)
  );

  // Next-state selection: emergency cuts greens, yellows always run to completion.
  always_comb begin
    next_state = state;
    nar_next   = next_after_red;
    done_next  = 1'b0;
    enter_walk = 1'b0;
    if (bus.tick) begin
      case (state)
        NS_GREEN, EW_LEFT, EW_GREEN, NS_LEFT: begin
          if (bus.emerg || expire) next_state = yellow_of(state);
          else                     next_state = state;
        end
        NS_YELLOW, EW_YELLOW, EW_YELLOW2, NS_YELLOW2: begin
          if (expire) begin
            next_state = ALL_RED;
            nar_next   = after_red_of(state);
          end else begin
            next_state = state;
          end
        end
        ALL_RED: begin
          if (!expire) begin
            next_state = state;
          end else if (bus.emerg) begin
            next_state = EMERG_HOLD;
          end else if (ped_pending) begin
            next_state = PED_WALK;
            enter_walk = 1'b1;
          end else begin
            next_state = next_after_red;
            done_next  = (next_after_red == NS_GREEN);
          end
        end
        EMERG_HOLD: begin
          if (bus.emerg) next_state = state;
          else           next_state = NS_GREEN;
        end
        PED_WALK: begin
          if (bus.emerg)   next_state = EMERG_HOLD;
          else if (expire) next_state = next_after_red;
          else             next_state = state;
        end
        default: next_state = NS_GREEN;
      endcase
    end else begin
      next_state = state;
    end
  end

  // Pedestrian request is sticky until the walk phase is entered.
  always_comb begin
    if (enter_walk) pend_next = 1'b0;
    else            pend_next = ped_pending | ped_set;
  end

  // State, resume phase, cycle pulse and pending walk registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= NS_GREEN;
      next_after_red <= EW_LEFT;
      cycle_done     <= 1'b0;
      ped_pending    <= 1'b0;
    end else begin
      state          <= next_state;
      next_after_red <= nar_next;
      cycle_done     <= done_next;
      ped_pending    <= pend_next;
    end
  end

  // Lamp decode straight from the state register.
  always_comb begin
    ns_lamp = RED;
    ew_lamp = RED;
    case (state)
      NS_GREEN:               ns_lamp = GREEN;
      NS_YELLOW, NS_YELLOW2:  ns_lamp = YELLOW;
      NS_LEFT:                ns_lamp = LEFT;
      EW_GREEN:               ew_lamp = GREEN;
      EW_YELLOW, EW_YELLOW2:  ew_lamp = YELLOW;
      EW_LEFT:                ew_lamp = LEFT;
      default: begin
        ns_lamp = RED;
        ew_lamp = RED;
      end
    endcase
  end

  assign bus.north      = ns_lamp;
  assign bus.south      = ns_lamp;
  assign bus.east       = ew_lamp;
  assign bus.west       = ew_lamp;
  assign bus.phase      = state;
  assign bus.cycle_done = cycle_done;
`ifdef PED_WALK_EN
  assign bus.ped_walk   = (state == PED_WALK);
`else
  assign bus.ped_walk   = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios plus random
// stimulus, all checked against a phase-sequence model. Honours PED_WALK_EN.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int G = 4, Y = 2, L = 3, A = 1, P = 3;
`ifdef PED_WALK_EN
  localparam bit PED_ON = 1'b1;
`else
  localparam bit PED_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  traffic_phase_ctrl_if tif();

  traffic_phase_ctrl #(
    .CNT_W(8), .GREEN_TIME(G), .YELLOW_TIME(Y), .LEFT_TIME(L),
    .ALLRED_TIME(A), .PED_TIME(P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: position in the 12-step ring, mode 0=ring 1=hold 2=walk.
  phase_t seq [12];
  int     dseq[12];
  int     m_pos, m_mode, m_el;
  bit     m_pend, m_cd;

  function automatic bit go_phase(input phase_t p);
    return (p == NS_GREEN) || (p == EW_LEFT) || (p == EW_GREEN) || (p == NS_LEFT);
  endfunction

  function automatic phase_t m_phase();
    if (m_mode == 1) return EMERG_HOLD;
    if (m_mode == 2) return PED_WALK;
    return seq[m_pos];
  endfunction

  function automatic logic [7:0] lamps_of(input phase_t p);
    case (p)
      NS_GREEN:              return {GREEN, GREEN, RED, RED};
      NS_YELLOW, NS_YELLOW2: return {YELLOW, YELLOW, RED, RED};
      NS_LEFT:               return {LEFT, LEFT, RED, RED};
      EW_GREEN:              return {RED, RED, GREEN, GREEN};
      EW_YELLOW, EW_YELLOW2: return {RED, RED, YELLOW, YELLOW};
      EW_LEFT:               return {RED, RED, LEFT, LEFT};
      default:               return {RED, RED, RED, RED};
    endcase
  endfunction

  task automatic model_update(input bit tk, input bit em, input bit pr, input bit r);
    bit new_pend;
    bit walked;
    if (r) begin
      m_pos = 0; m_mode = 0; m_el = 0; m_pend = 1'b0; m_cd = 1'b0;
      return;
    end
    m_cd = 1'b0;
    walked = 1'b0;
    new_pend = m_pend | (pr & PED_ON);
    if (tk) begin
      if (m_mode == 0) begin
        if (em && go_phase(seq[m_pos])) begin
          m_pos = m_pos + 1; m_el = 0;
        end else if (m_el + 1 == dseq[m_pos]) begin
          m_el = 0;
          if (seq[m_pos] == ALL_RED) begin
            if (em) m_mode = 1;
            else if (m_pend) begin m_mode = 2; walked = 1'b1; end
            else begin
              m_pos = (m_pos + 1) % 12;
              m_cd  = (m_pos == 0);
            end
          end else begin
            m_pos = m_pos + 1;
          end
        end else begin
          m_el = m_el + 1;
        end
      end else if (m_mode == 1) begin
        if (!em) begin m_mode = 0; m_pos = 0; m_el = 0; end
      end else begin
        if (em) begin m_mode = 1; m_el = 0; end
        else if (m_el + 1 == P) begin m_mode = 0; m_pos = (m_pos + 1) % 12; m_el = 0; end
        else m_el = m_el + 1;
      end
    end
    m_pend = walked ? 1'b0 : new_pend;
  endtask

  task automatic compare();
    phase_t     ep;
    logic [7:0] el, al;
    bit         ew;
    ep = m_phase();
    el = lamps_of(ep);
    ew = (m_mode == 2);
    al = {tif.north, tif.south, tif.east, tif.west};
    vectors++;
    if (tif.phase !== ep || al !== el || tif.ped_walk !== ew || tif.cycle_done !== m_cd) begin
      miscompares++;
      $display("FAIL model_cmp t=%0t: phase %0d lamps %h walk %b done %b, expected phase %0d lamps %h walk %b done %b",
               $time, tif.phase, al, tif.ped_walk, tif.cycle_done, ep, el, ew, m_cd);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit tk, input bit em, input bit pr, input bit r);
    tif.tick = tk; tif.emerg = em; tif.ped_req = pr; rst = r;
    @(posedge clk);
    model_update(tk, em, pr, r);
    #1;
    compare();
  endtask

  initial begin
    int  walk_cnt;
    int  after_walk;
    bit  prev_walk;
    bit  em;
    seq  = '{NS_GREEN, NS_YELLOW, ALL_RED, EW_LEFT, EW_YELLOW, ALL_RED,
             EW_GREEN, EW_YELLOW2, ALL_RED, NS_LEFT, NS_YELLOW2, ALL_RED};
    dseq = '{G, Y, A, L, Y, A, G, Y, A, L, Y, A};
    m_pos = 0; m_mode = 0; m_el = 0; m_pend = 1'b0; m_cd = 1'b0;
    tif.tick = 1'b0; tif.emerg = 1'b0; tif.ped_req = 1'b0;

    // Reset, with tick and emerg high to show reset dominates.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    lit("reset_phase", int'(tif.phase), int'(NS_GREEN));
    lit("reset_lamps", int'({tif.north, tif.south, tif.east, tif.west}), 32'h0A);
    lit("reset_walk", int'(tif.ped_walk), 0);
    lit("reset_done", int'(tif.cycle_done), 0);

    // Full cycle with tick every clock: 26 ticks per ring.
    for (int n = 1; n <= 27; n++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (n == 3)  lit("ns_green_last", int'(tif.phase), int'(NS_GREEN));
      if (n == 4)  lit("ns_yellow", int'(tif.phase), int'(NS_YELLOW));
      if (n == 6)  lit("all_red", int'(tif.phase), int'(ALL_RED));
      if (n == 7)  lit("ew_left_east", int'(tif.east), int'(LEFT));
      if (n == 25) lit("done_low_before", int'(tif.cycle_done), 0);
      if (n == 26) lit("cycle_done_pulse", int'(tif.cycle_done), 1);
      if (n == 27) lit("cycle_done_single", int'(tif.cycle_done), 0);
    end

    // Tick every third clock: each phase stretches to 3*T clocks.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 90; i++) begin
      step(i % 3 == 2, 1'b0, 1'b0, 1'b0);
      if (i == 10) lit("slow_green", int'(tif.phase), int'(NS_GREEN));
      if (i == 11) lit("slow_yellow", int'(tif.phase), int'(NS_YELLOW));
    end

    // Emergency during NS_GREEN at cnt=1.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("emerg_cut", int'(tif.phase), int'(NS_YELLOW));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("emerg_yellow_full", int'(tif.phase), int'(NS_YELLOW));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("emerg_allred", int'(tif.phase), int'(ALL_RED));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("emerg_hold", int'(tif.phase), int'(EMERG_HOLD));
    lit("hold_lamps", int'({tif.north, tif.south, tif.east, tif.west}), 32'hAA);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("hold_kept", int'(tif.phase), int'(EMERG_HOLD));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    lit("hold_exit", int'(tif.phase), int'(NS_GREEN));
    lit("hold_exit_nodone", int'(tif.cycle_done), 0);

    // Reset in the middle of EW_GREEN.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && m_phase() != EW_GREEN; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    lit("mid_ew_green", int'(tif.phase), int'(EW_GREEN));
    step(1'b1, 1'b1, 1'b0, 1'b1);
    lit("midrst_phase", int'(tif.phase), int'(NS_GREEN));
    lit("midrst_lamps", int'({tif.north, tif.south, tif.east, tif.west}), 32'h0A);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    lit("midrst_cnt0_a", int'(tif.phase), int'(NS_GREEN));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    lit("midrst_cnt0_b", int'(tif.phase), int'(NS_YELLOW));

`ifdef PED_WALK_EN
    // Walk request during EW_LEFT is served after the following ALL_RED.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && m_phase() != EW_LEFT; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    walk_cnt = 0; after_walk = -1; prev_walk = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (tif.ped_walk) walk_cnt++;
      if (prev_walk && !tif.ped_walk && after_walk < 0) after_walk = int'(tif.phase);
      prev_walk = tif.ped_walk;
    end
    lit("walk_len", walk_cnt, P);
    lit("walk_resume", after_walk, int'(EW_GREEN));

    // Walk request together with emergency: hold first, walk at next ALL_RED end.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("ped_emerg_hold", int'(tif.phase), int'(EMERG_HOLD));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    walk_cnt = 0; after_walk = -1; prev_walk = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (tif.ped_walk) walk_cnt++;
      if (prev_walk && !tif.ped_walk && after_walk < 0) after_walk = int'(tif.phase);
      prev_walk = tif.ped_walk;
    end
    lit("ped_retained_len", walk_cnt, P);
    lit("ped_retained_resume", after_walk, int'(EW_LEFT));
`else
    // Without the walk feature a button press must not change anything.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, (i % 5) == 0, 1'b0);
      lit("no_walk", int'(tif.ped_walk), 0);
    end
`endif

    // Random traffic: irregular ticks, sticky emergencies, button presses, rare resets.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    em = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) em = ~em;
      step($urandom_range(0, 3) != 0, em, $urandom_range(0, 29) == 0,
           $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
